// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
// Optional per-channel drain counters are enabled with DEMUX_CNT_EN.
package demux_pkg;
   localparam int CH_NUM = 4;
   localparam int SEL_W  = 2;
   localparam int WIDTH  = 5;
   typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/demux_slot.sv
// One-entry output register for one channel: load, drain and full flag.
// With DEMUX_CNT_EN a saturating drain counter is kept alongside.
module demux_slot
   import demux_pkg::*;
#(
   parameter int WIDTH = demux_pkg::WIDTH
`ifdef DEMUX_CNT_EN
  ,parameter int CNT_W = 8
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic             ready_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             full_o,
   output logic [WIDTH-1:0] data_o
`ifdef DEMUX_CNT_EN
  ,output logic [CNT_W-1:0] cnt_o
`endif
);

   logic             full_q, full_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             drain;

   assign drain = full_q & ready_i;

   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (drain) full_d = 1'b0;
      // A load in the drain cycle refills the slot, keeping full set.
      if (load_i) begin
         full_d = 1'b1;
         data_d = data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

   assign full_o = full_q;
   assign data_o = data_q;

`ifdef DEMUX_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (drain && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/demux4t1_5_stream.sv
// Steers one valid/ready stream into four independently buffered channels.
// Build with DEMUX_CNT_EN to expose per-channel drain counters on o_cnt.
module demux4t1_5_stream
   import demux_pkg::*;
#(
   parameter int WIDTH = demux_pkg::WIDTH
`ifdef DEMUX_CNT_EN
  ,parameter int CNT_W = 8
`endif
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  sel_t                    s,
   input  logic [WIDTH-1:0]        i_data,
   input  logic                    i_valid,
   output logic                    i_ready,
   output logic [CH_NUM*WIDTH-1:0] o_data,
   output logic [CH_NUM-1:0]       o_valid,
   input  logic [CH_NUM-1:0]       o_ready
`ifdef DEMUX_CNT_EN
  ,output logic [CH_NUM*CNT_W-1:0] o_cnt
`endif
);

   logic              accept;
   logic [CH_NUM-1:0] load;

   // The addressed slot can take data if empty or being drained now.
   assign i_ready = !o_valid[s] | o_ready[s];
   assign accept  = i_valid & i_ready;

   for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
      assign load[k] = accept & (s == sel_t'(k));

      demux_slot #(
         .WIDTH (WIDTH)
`ifdef DEMUX_CNT_EN
        ,.CNT_W (CNT_W)
`endif
      ) u_slot (
         .clk     (clk),
         .rst_n   (rst_n),
         .load_i  (load[k]),
         .ready_i (o_ready[k]),
         .data_i  (i_data),
         .full_o  (o_valid[k]),
         .data_o  (o_data[k*WIDTH +: WIDTH])
`ifdef DEMUX_CNT_EN
        ,.cnt_o   (o_cnt[k*CNT_W +: CNT_W])
`endif
      );
   end

endmodule
